// File: rtl/mem_map_pkg.sv
// Shared CPU memory map and the switch debounce FSM state type.
package mem_map_pkg;

    localparam logic [15:0] INSTRUCTION_MEM   = 16'h0000;
    localparam logic [15:0] INTERRUPT_CONTROL = 16'h8000;
    localparam logic [15:0] DATA_STACK        = 16'hB000;
    localparam logic [15:0] IO_MEM            = 16'hC000;
    localparam logic [15:0] SWITCHES_LOC      = 16'hCFFD;
    localparam logic [15:0] LEDS_LOC          = 16'hCFFE;
    localparam logic [15:0] SW_STATUS_LOC     = 16'hCFFF;
    localparam logic [15:0] SW_MASK_LOC       = 16'hD000;

    typedef enum logic {
        DbIdle,
        DbCount
    } db_state_e;

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer plus a debounce FSM shared across all switch bits.
module switch_debounce
    import mem_map_pkg::*;
#(
    parameter int unsigned SW_WIDTH        = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SW_WIDTH-1:0] switches,
    output logic [SW_WIDTH-1:0] stable,
    output logic                update,
    output logic [SW_WIDTH-1:0] delta
);

    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    db_state_e           state;
    logic [SW_WIDTH-1:0] meta;
    logic [SW_WIDTH-1:0] sync;
    logic [SW_WIDTH-1:0] cand;
    logic [CNT_W-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= DbIdle;
            meta   <= '0;
            sync   <= '0;
            stable <= '0;
            cand   <= '0;
            cnt    <= '0;
        end else begin
            meta <= switches;
            sync <= meta;
            unique case (state)
                DbIdle: begin
                    if (sync != stable) begin
                        cand  <= sync;
                        cnt   <= '0;
                        state <= DbCount;
                    end
                end
                DbCount: begin
                    if (sync == stable) begin
                        state <= DbIdle;
                    end else if (sync != cand) begin
                        cand <= sync;
                        cnt  <= '0;
                    end else if (cnt == CNT_MAX) begin
                        stable <= cand;
                        state  <= DbIdle;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= DbIdle;
            endcase
        end
    end

    // Strobe is high on the very edge that loads stable, so pending can update alongside it.
    assign update = (state == DbCount) && (sync != stable) && (sync == cand) && (cnt == CNT_MAX);
    assign delta  = stable ^ cand;

endmodule

// File: rtl/switch_input_port.sv
// Memory-mapped switch input port: debounced value, W1C change flags, optional masked IRQ.
// Define SW_IRQ_EN to build the mask register and the interrupt output.
module switch_input_port
    import mem_map_pkg::*;
#(
    parameter int unsigned SW_WIDTH        = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic [15:0] SWITCHES_ADDR   = SWITCHES_LOC,
    parameter logic [15:0] STATUS_ADDR     = SW_STATUS_LOC,
    parameter logic [15:0] MASK_ADDR       = SW_MASK_LOC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SW_WIDTH-1:0] switches,
    input  logic [15:0]         address,
    input  logic                wren,
    input  logic [15:0]         data_in,
    output logic [15:0]         rd_data,
    output logic                rd_hit,
    output logic                irq
);

    logic [SW_WIDTH-1:0] stable;
    logic [SW_WIDTH-1:0] delta;
    logic                update;
    logic [SW_WIDTH-1:0] pending;
    logic [SW_WIDTH-1:0] w1c;
    logic [SW_WIDTH-1:0] set_bits;
    logic [15:0]         rd_value;
    logic                rd_match;
    logic                unused_data;

    switch_debounce #(
        .SW_WIDTH       (SW_WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .switches(switches),
        .stable  (stable),
        .update  (update),
        .delta   (delta)
    );

`ifdef SW_IRQ_EN
    logic [SW_WIDTH-1:0] mask;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mask <= '0;
            irq  <= 1'b0;
        end else begin
            if (wren && address == MASK_ADDR) begin
                mask <= data_in[SW_WIDTH-1:0];
            end
            irq <= |(pending & mask);
        end
    end
`else
    logic unused_mask_addr;

    assign unused_mask_addr = (address == MASK_ADDR);
    assign irq              = 1'b0;
`endif

    always_comb begin
        rd_match = 1'b1;
        rd_value = '0;
        if (address == SWITCHES_ADDR) begin
            rd_value = 16'(stable);
        end else if (address == STATUS_ADDR) begin
            rd_value = 16'(pending);
`ifdef SW_IRQ_EN
        end else if (address == MASK_ADDR) begin
            rd_value = 16'(mask);
`endif
        end else begin
            rd_match = 1'b0;
        end
    end

    assign w1c         = (wren && address == STATUS_ADDR) ? data_in[SW_WIDTH-1:0] : '0;
    assign set_bits    = update ? delta : '0;
    assign unused_data = ^data_in;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending <= '0;
            rd_hit  <= 1'b0;
            rd_data <= '0;
        end else begin
            // A debounce set beats a simultaneous clear of the same bit.
            pending <= (pending & ~w1c) | set_bits;
            rd_hit  <= !wren && rd_match;
            rd_data <= (!wren && rd_match) ? rd_value : 16'h0000;
        end
    end

endmodule

// File: tb/tb_switch_input_port.sv
// Directed bench for switch_input_port with a sliding-window reference model.
module tb_switch_input_port;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;
`ifdef SW_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic [W-1:0]  switches = '0;
    logic [15:0]   address  = 16'hCFFD;
    logic          wren     = 1'b0;
    logic [15:0]   data_in  = 16'h0000;
    logic [15:0]   rd_data;
    logic          rd_hit;
    logic          irq;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    switch_input_port #(
        .SW_WIDTH       (W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .switches(switches),
        .address (address),
        .wren    (wren),
        .data_in (data_in),
        .rd_data (rd_data),
        .rd_hit  (rd_hit),
        .irq     (irq)
    );

    // Model: stable takes a new value once the synchronized input has shown it on D+1
    // consecutive samples.
    logic [W-1:0] m_s1, m_s2, m_stable, m_pend, m_mask, m_run_val;
    int           m_run_len;
    logic         m_hit, m_irq;
    logic [15:0]  m_data;

    always @(posedge clk) begin : model
        logic [W-1:0] s, newbits, clr;
        logic         rh;
        logic [15:0]  rv;
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_pend = '0; m_mask = '0;
            m_run_val = '0; m_run_len = 0; m_hit = 1'b0; m_irq = 1'b0; m_data = 16'h0;
        end else begin
            s = m_s2;
            if (m_run_len > 0 && s == m_run_val) m_run_len++;
            else begin
                m_run_val = s;
                m_run_len = 1;
            end
            newbits = (m_run_val != m_stable && m_run_len >= D + 1) ? (m_stable ^ m_run_val) : '0;
            rh = 1'b0;
            rv = 16'h0;
            if (!wren) begin
                if (address == 16'hCFFD) begin rh = 1'b1; rv = {8'h00, m_stable}; end
                else if (address == 16'hCFFF) begin rh = 1'b1; rv = {8'h00, m_pend}; end
                else if (IRQ_EN && address == 16'hD000) begin rh = 1'b1; rv = {8'h00, m_mask}; end
            end
            m_irq  = IRQ_EN && (|(m_pend & m_mask));
            clr    = (wren && address == 16'hCFFF) ? data_in[W-1:0] : '0;
            m_pend = (m_pend & ~clr) | newbits;
            if (IRQ_EN && wren && address == 16'hD000) m_mask = data_in[W-1:0];
            if (newbits != '0) m_stable = m_run_val;
            m_hit  = rh;
            m_data = rv;
            m_s2   = m_s1;
            m_s1   = switches;
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_rd_hit", 16'(rd_hit), 16'(m_hit));
            check("cyc_rd_data", rd_data, m_data);
            check("cyc_irq", 16'(irq), 16'(m_irq));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        address = a; wren = 1'b1; data_in = d;
        tick();
        wren = 1'b0; data_in = 16'h0; address = 16'hCFFD;
    endtask

    task automatic rd(input logic [15:0] a);
        address = a;
        tick();
        address = 16'hCFFD;
    endtask

    initial begin
        // 1: reset and read
        tick();
        chk_en = 1'b1;
        tick(2);
        reset = 1'b1;
        rd(16'hCFFD);
        check("rst_sw_hit", 16'(rd_hit), 16'h1);
        check("rst_sw_data", rd_data, 16'h0000);
        check("rst_irq", 16'(irq), 16'h0);
        rd(16'h1234);
        check("miss_hit", 16'(rd_hit), 16'h0);
        check("miss_data", rd_data, 16'h0000);

        // 2: clean change, visible on the read after the 7th edge
        switches = 8'hA5;
        tick(7);
        check("clean_pre", rd_data, 16'h0000);
        tick();
        check("clean_sw", rd_data, 16'h00A5);
        rd(16'hCFFF);
        check("clean_status", rd_data, 16'h00A5);

        // 3: bounce on bit 0
        switches = 8'h00;
        tick(10);
        wr(16'hCFFF, 16'h00FF);
        for (int i = 0; i < 10; i++) begin
            switches[0] = ~switches[0];
            tick(2);
        end
        rd(16'hCFFF);
        check("bounce_no_pend", rd_data, 16'h0000);
        switches = 8'h01;
        tick(7);
        check("bounce_pre", rd_data, 16'h0000);
        tick();
        check("bounce_sw", rd_data, 16'h0001);
        tick(4);
        rd(16'hCFFF);
        check("bounce_pend", rd_data, 16'h0001);

        // 4: mask, irq, W1C, write to read-only address
        switches = 8'h00;
        tick(10);
        wr(16'hCFFF, 16'h00FF);
        wr(16'hD000, 16'h0001);
        rd(16'hD000);
        check("mask_hit", 16'(rd_hit), 16'(IRQ_EN));
        check("mask_data", rd_data, IRQ_EN ? 16'h0001 : 16'h0000);
        switches = 8'h01;
        tick(10);
        check("irq_set", 16'(irq), 16'(IRQ_EN));
        wr(16'hCFFF, 16'h0001);
        check("wr_no_hit", 16'(rd_hit), 16'h0);
        check("irq_hold", 16'(irq), 16'(IRQ_EN));
        tick();
        check("irq_clr", 16'(irq), 16'h0);
        rd(16'hCFFF);
        check("w1c_status", rd_data, 16'h0000);
        wr(16'hCFFD, 16'hFFFF);
        rd(16'hCFFD);
        check("ro_sw", rd_data, 16'h0001);
        rd(16'hCFFF);
        check("ro_status", rd_data, 16'h0000);

        // 5: W1C of bits 3 and 4 on the edge that sets bit 3
        switches = 8'h11;
        tick(10);
        switches = 8'h19;
        tick(6);
        wr(16'hCFFF, 16'h0018);
        rd(16'hCFFF);
        check("collide", rd_data, 16'h0008);

        // 6: reset mid-count, no stale update afterwards
        switches = 8'h06;
        tick(4);
        reset    = 1'b0;
        switches = 8'h00;
        tick();
        check("rst_mid_hit", 16'(rd_hit), 16'h0);
        check("rst_mid_data", rd_data, 16'h0000);
        check("rst_mid_irq", 16'(irq), 16'h0);
        reset = 1'b1;
        tick(12);
        rd(16'hCFFD);
        check("stale_sw", rd_data, 16'h0000);
        rd(16'hCFFF);
        check("stale_status", rd_data, 16'h0000);
        rd(16'hD000);
        check("post_rst_mask", rd_data, 16'h0000);
        tick(2);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
